atm_txn_arbiter: RTL and testbench
==================================

Name: atm_txn_arbiter

Overview:
- Shared account-ledger controller for multiple ATM front-end FSMs (terminals).
- Round-robin arbitrates terminal requests and sequences one atomic read-check-write per grant on an internal balance register file.
- Supports deposit, withdraw, transfer and balance inquiry, and returns a status and the resulting balance to the granted terminal.

Parameters:
- NUM_REQ, 2, number of requesting terminals (2..4)
- NUM_ACCTS, 3, number of accounts in the ledger
- IDX_W, 2, account index width
- AMT_W, 6, transaction amount width
- BAL_W, 12, balance width, unsigned
- INIT_BAL, 100, balance loaded into every account on reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-terminal request, held until ack
- req_op  in  2*NUM_REQ  per-terminal op: 00 deposit, 01 withdraw, 10 transfer, 11 inquiry
- req_src  in  IDX_W*NUM_REQ  per-terminal source account index
- req_dst  in  IDX_W*NUM_REQ  per-terminal destination index (transfer only)
- req_amt  in  AMT_W*NUM_REQ  per-terminal amount
- grant  out  NUM_REQ  one-hot, granted terminal, held RD through DONE
- ack  out  NUM_REQ  one-cycle pulse to granted terminal in DONE
- rsp_status  out  2  00 OK, 01 INSUFFICIENT, 10 BAD_ACCT, 11 OVERFLOW; valid with ack
- rsp_balance  out  BAL_W  resulting source balance; valid with ack
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; grant=0, ack=0, rsp_status=0, rsp_balance=0, busy=0; RR pointer=0; all balances=INIT_BAL. Reset mid-transaction drops it; no partial write.
- FSM: IDLE -> RD -> CHK -> WR -> DONE -> IDLE. Each state lasts 1 cycle; ack asserts 4 edges after the IDLE edge that captured the request.
- IDLE: if any req, pick the first set bit searching from the pointer upward with wrap. Latch that terminal's op/src/dst/amt, set grant, go RD. Pointer becomes (winner+1) mod NUM_REQ. If no req, stay in IDLE.
- RD: read src_bal and dst_bal into registers.
- CHK: compute status and new balances. Sums use BAL_W+1 bits internally.
  - Priority: BAD_ACCT > INSUFFICIENT > OVERFLOW > OK.
  - BAD_ACCT: src >= NUM_ACCTS; for transfer, also dst >= NUM_ACCTS or dst == src.
  - Deposit: OVERFLOW if src_bal+amt > 2^BAL_W-1.
  - Withdraw: INSUFFICIENT if amt > src_bal. amt == src_bal is OK and gives a result of 0.
  - Transfer: INSUFFICIENT if amt > src_bal; OVERFLOW if dst_bal+amt overflows.
  - Inquiry: always OK unless BAD_ACCT; no write.
  - amt = 0 is OK and leaves balances unchanged.
- WR: write only if status OK and op != inquiry. Transfer writes src and dst on the same edge (atomic).
- DONE: ack[winner]=1, rsp_status and rsp_balance registered.
  - rsp_balance = new src balance when OK.
  - rsp_balance = unchanged src balance on INSUFFICIENT or OVERFLOW.
  - rsp_balance = 0 on BAD_ACCT.
  - grant clears on the exit edge.
- Requester rules: keep payload stable while req is high; drop req on the edge after ack. A req still high in IDLE after its own ack is treated as a new request.
- Requests arriving while busy wait; they are not lost and not queued beyond the req level.
- Requests that drop req before grant are ignored.

Optional Feature:
- Macro ATM_AUDIT_EN.
- Defined: adds outputs audit_ok_cnt [7:0] and audit_err_cnt [7:0], both reset to 0.
  - audit_ok_cnt increments in DONE on OK; audit_err_cnt increments in DONE on any other status.
  - Both saturate at 255.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, T0 inquiry acct 1 -> ack[0] 4 cycles after capture, status OK, balance 100, busy high 4 cycles.
- T0 withdraw 40 from acct 0, then withdraw 61 from acct 0 -> OK/60, then INSUFFICIENT/60; acct 0 remains 60.
- T1 transfer 30 acct 2->0 -> OK/70; T0 inquiry acct 0 -> 130. Transfer dst=src, or dst=3 -> BAD_ACCT, balance 0, no write.
- req=2'b11 held continuously, each terminal re-raising req after its ack -> grants alternate T0, T1, T0, T1; no starvation.
- Deposits of 63 to acct 1 until it would exceed 4095 -> final attempt OVERFLOW, balance unchanged; amt=0 deposit -> OK, unchanged.
- rst_n low during CHK of transfer 50 acct 0->1 -> both balances 100 after reset, no ack; with ATM_AUDIT_EN, counters read 0 after reset and count 1 OK/1 error after one OK and one INSUFFICIENT.

Source files
------------

// File: rtl/atm_txn_arbiter.sv
// Round-robin arbiter serialising ATM terminal transactions onto a shared balance ledger.
// Optional ATM_AUDIT_EN adds saturating OK/error transaction counters.
module atm_txn_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_ACCTS = 3,
    parameter int IDX_W     = 2,
    parameter int AMT_W     = 6,
    parameter int BAL_W     = 12,
    parameter int INIT_BAL  = 100
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [2*NUM_REQ-1:0]     req_op,
    input  logic [IDX_W*NUM_REQ-1:0] req_src,
    input  logic [IDX_W*NUM_REQ-1:0] req_dst,
    input  logic [AMT_W*NUM_REQ-1:0] req_amt,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [1:0]               rsp_status,
    output logic [BAL_W-1:0]         rsp_balance,
    output logic                     busy
`ifdef ATM_AUDIT_EN
    ,
    output logic [7:0]               audit_ok_cnt,
    output logic [7:0]               audit_err_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;

    localparam logic [1:0] OP_DEP  = 2'b00;
    localparam logic [1:0] OP_WDR  = 2'b01;
    localparam logic [1:0] OP_XFER = 2'b10;
    localparam logic [1:0] OP_INQ  = 2'b11;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_INS  = 2'b01;
    localparam logic [1:0] ST_BAD  = 2'b10;
    localparam logic [1:0] ST_OVF  = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_CHK, S_WR, S_DONE} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr_q;
    logic [BAL_W-1:0]   bal [NUM_ACCTS];

    logic               found_c;
    logic [PTR_W-1:0]   win_c;
    logic [PTR_W-1:0]   rr_idx;
    logic [1:0]         sel_op_c;
    logic [IDX_W-1:0]   sel_src_c, sel_dst_c;
    logic [AMT_W-1:0]   sel_amt_c;
    logic [BAL_W-1:0]   src_bal_c, dst_bal_c;

    logic [1:0]         op_p0;
    logic [IDX_W-1:0]   src_p0, dst_p0;
    logic [AMT_W-1:0]   amt_p0;
    logic [BAL_W-1:0]   src_bal_p1, dst_bal_p1;
    logic [1:0]         st_p2;
    logic [BAL_W-1:0]   rbal_p2, dst_new_p2;

    // Returns {status, response balance}; the response balance doubles as the new source balance on OK.
    function automatic logic [BAL_W+1:0] chk_txn(
        input logic [1:0]       op,
        input logic [IDX_W-1:0] s,
        input logic [IDX_W-1:0] d,
        input logic [AMT_W-1:0] a,
        input logic [BAL_W-1:0] sb,
        input logic [BAL_W-1:0] db
    );
        logic [BAL_W:0]   amt_x, sum_s, sum_d;
        logic             bad, insuf, ovf;
        logic [1:0]       st;
        logic [BAL_W-1:0] nb;
        amt_x = (BAL_W+1)'(a);
        sum_s = {1'b0, sb} + amt_x;
        sum_d = {1'b0, db} + amt_x;
        bad   = (int'(s) >= NUM_ACCTS) ||
                ((op == OP_XFER) && ((int'(d) >= NUM_ACCTS) || (d == s)));
        insuf = ((op == OP_WDR) || (op == OP_XFER)) && (amt_x > {1'b0, sb});
        ovf   = ((op == OP_DEP) && sum_s[BAL_W]) || ((op == OP_XFER) && sum_d[BAL_W]);
        if (bad) begin
            st = ST_BAD;
            nb = '0;
        end else if (insuf) begin
            st = ST_INS;
            nb = sb;
        end else if (ovf) begin
            st = ST_OVF;
            nb = sb;
        end else begin
            st = ST_OK;
            case (op)
                OP_DEP:          nb = sum_s[BAL_W-1:0];
                OP_WDR, OP_XFER: nb = sb - BAL_W'(a);
                default:         nb = sb;
            endcase
        end
        return {st, nb};
    endfunction

    always_comb begin
        found_c = 1'b0;
        win_c   = '0;
        rr_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            rr_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found_c && req[rr_idx]) begin
                found_c = 1'b1;
                win_c   = rr_idx;
            end
        end
    end

    always_comb begin
        sel_op_c  = '0;
        sel_src_c = '0;
        sel_dst_c = '0;
        sel_amt_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_c == PTR_W'(i)) begin
                sel_op_c  = req_op[2*i +: 2];
                sel_src_c = req_src[IDX_W*i +: IDX_W];
                sel_dst_c = req_dst[IDX_W*i +: IDX_W];
                sel_amt_c = req_amt[AMT_W*i +: AMT_W];
            end
        end
    end

    always_comb begin
        src_bal_c = '0;
        dst_bal_c = '0;
        for (int i = 0; i < NUM_ACCTS; i++) begin
            if (src_p0 == IDX_W'(i)) src_bal_c = bal[i];
            if (dst_p0 == IDX_W'(i)) dst_bal_c = bal[i];
        end
    end

    // p0: payload latch at grant; p1: ledger read; p2: checked result
    always_ff @(posedge clk) begin
        if (state == S_IDLE && found_c) begin
            op_p0  <= sel_op_c;
            src_p0 <= sel_src_c;
            dst_p0 <= sel_dst_c;
            amt_p0 <= sel_amt_c;
        end
        if (state == S_RD) begin
            src_bal_p1 <= src_bal_c;
            dst_bal_p1 <= dst_bal_c;
        end
        if (state == S_CHK) begin
            {st_p2, rbal_p2} <= chk_txn(op_p0, src_p0, dst_p0, amt_p0, src_bal_p1, dst_bal_p1);
            dst_new_p2       <= dst_bal_p1 + BAL_W'(amt_p0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= '0;
            ack         <= '0;
            rsp_status  <= '0;
            rsp_balance <= '0;
            busy        <= 1'b0;
            ptr_q       <= '0;
            for (int i = 0; i < NUM_ACCTS; i++) bal[i] <= BAL_W'(INIT_BAL);
        end else begin
            ack <= '0;
            case (state)
                S_IDLE: if (found_c) begin
                    grant <= NUM_REQ'(1) << win_c;
                    ptr_q <= PTR_W'((int'(win_c) + 1) % NUM_REQ);
                    busy  <= 1'b1;
                    state <= S_RD;
                end
                S_RD:  state <= S_CHK;
                S_CHK: state <= S_WR;
                S_WR: begin
                    // Both legs of a transfer land on the same edge so the ledger is never half-updated.
                    if (st_p2 == ST_OK && op_p0 != OP_INQ) begin
                        for (int i = 0; i < NUM_ACCTS; i++) begin
                            if (src_p0 == IDX_W'(i)) bal[i] <= rbal_p2;
                            if (op_p0 == OP_XFER && dst_p0 == IDX_W'(i)) bal[i] <= dst_new_p2;
                        end
                    end
                    ack         <= grant;
                    rsp_status  <= st_p2;
                    rsp_balance <= rbal_p2;
                    state       <= S_DONE;
                end
                S_DONE: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ATM_AUDIT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audit_ok_cnt  <= '0;
            audit_err_cnt <= '0;
        end else if (state == S_DONE) begin
            if (rsp_status == ST_OK) audit_ok_cnt  <= sat_inc(audit_ok_cnt);
            else                     audit_err_cnt <= sat_inc(audit_err_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_atm_txn_arbiter.sv
// Scoreboard bench for atm_txn_arbiter: directed transactions push expected responses, an ack monitor checks them.
module tb_atm_txn_arbiter;
    localparam int NUM_REQ = 2, NUM_ACCTS = 3, IDX_W = 2, AMT_W = 6, BAL_W = 12;
    localparam logic [1:0] OP_DEP = 2'b00, OP_WDR = 2'b01, OP_XFER = 2'b10, OP_INQ = 2'b11;
    localparam logic [1:0] ST_OK = 2'b00, ST_INS = 2'b01, ST_BAD = 2'b10, ST_OVF = 2'b11;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [NUM_REQ-1:0]       req = '0;
    logic [2*NUM_REQ-1:0]     req_op = '0;
    logic [IDX_W*NUM_REQ-1:0] req_src = '0;
    logic [IDX_W*NUM_REQ-1:0] req_dst = '0;
    logic [AMT_W*NUM_REQ-1:0] req_amt = '0;
    logic [NUM_REQ-1:0]       grant, ack;
    logic [1:0]               rsp_status;
    logic [BAL_W-1:0]         rsp_balance;
    logic                     busy;
`ifdef ATM_AUDIT_EN
    logic [7:0]               audit_ok_cnt, audit_err_cnt;
`endif

    atm_txn_arbiter #(.NUM_REQ(NUM_REQ), .NUM_ACCTS(NUM_ACCTS), .IDX_W(IDX_W),
                      .AMT_W(AMT_W), .BAL_W(BAL_W), .INIT_BAL(100)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_op(req_op), .req_src(req_src),
        .req_dst(req_dst), .req_amt(req_amt), .grant(grant), .ack(ack),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance), .busy(busy)
`ifdef ATM_AUDIT_EN
        , .audit_ok_cnt(audit_ok_cnt), .audit_err_cnt(audit_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         term;
        logic [1:0] st;
        int         bal;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        exp_t e;
        if (ack != '0) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=%b expected no ack at %0t", ack, $time);
            end else begin
                e = sb.pop_front();
                check("ack_term", int'(ack), 1 << e.term);
                check("rsp_status", int'(rsp_status), int'(e.st));
                check("rsp_balance", int'(rsp_balance), e.bal);
            end
        end
    end

    task automatic set_payload(input int t, input logic [1:0] op, input int src, input int dst, input int amt);
        req_op[2*t +: 2]          = op;
        req_src[IDX_W*t +: IDX_W] = IDX_W'(src);
        req_dst[IDX_W*t +: IDX_W] = IDX_W'(dst);
        req_amt[AMT_W*t +: AMT_W] = AMT_W'(amt);
    endtask

    task automatic txn(input int t, input logic [1:0] op, input int src, input int dst, input int amt,
                       output int lat, output int bcnt);
        @(negedge clk);
        set_payload(t, op, src, dst, amt);
        req[t] = 1'b1;
        lat  = 0;
        bcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (ack[t]) break;
        end
        if (!ack[t]) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: terminal %0d got no ack, expected one within 40 cycles", t);
        end
        @(posedge clk);
        #1 req[t] = 1'b0;
    endtask

    task automatic run(input int t, input logic [1:0] op, input int src, input int dst, input int amt,
                       input logic [1:0] est, input int ebal);
        int l, b;
        sb.push_back('{t, est, ebal});
        txn(t, op, src, dst, amt, l, b);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int lat, bcnt;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", int'(grant), 0);
        check("rst_ack", int'(ack), 0);
        check("rst_status", int'(rsp_status), 0);
        check("rst_balance", int'(rsp_balance), 0);
        check("rst_busy", int'(busy), 0);
        rst_n = 1'b1;

        // Inquiry latency and busy window
        sb.push_back('{0, ST_OK, 100});
        txn(0, OP_INQ, 1, 0, 0, lat, bcnt);
        check("ack_latency", lat, 4);
        check("busy_cycles", bcnt, 4);
        @(negedge clk);
        check("busy_after_done", int'(busy), 0);
        run(0, OP_INQ, 3, 0, 0, ST_BAD, 0);

        // Transfer group from a fresh ledger
        do_reset();
        run(1, OP_XFER, 2, 0, 30, ST_OK, 70);
        run(0, OP_INQ, 0, 0, 0, ST_OK, 130);
        run(1, OP_XFER, 2, 2, 5, ST_BAD, 0);
        run(1, OP_XFER, 0, 3, 5, ST_BAD, 0);
        run(0, OP_INQ, 2, 0, 0, ST_OK, 70);
        run(1, OP_INQ, 0, 0, 0, ST_OK, 130);

        // Both terminals contending; pointer now favours T0
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{0, ST_OK, 130});
            sb.push_back('{1, ST_OK, 70});
        end
        fork
            begin
                int l0, b0;
                repeat (3) txn(0, OP_INQ, 0, 0, 0, l0, b0);
            end
            begin
                int l1, b1;
                repeat (3) txn(1, OP_INQ, 2, 0, 0, l1, b1);
            end
        join

        // Deposit up to the balance ceiling
        for (int k = 1; k <= 63; k++) run(0, OP_DEP, 1, 0, 63, ST_OK, 100 + 63*k);
        run(0, OP_DEP, 1, 0, 63, ST_OVF, 4069);
        run(0, OP_DEP, 1, 0, 0, ST_OK, 4069);
        run(1, OP_DEP, 1, 0, 26, ST_OK, 4095);
        run(0, OP_DEP, 1, 0, 1, ST_OVF, 4095);
        run(1, OP_XFER, 0, 1, 1, ST_OVF, 130);

        // Reset while a transfer is in CHK
        @(negedge clk);
        set_payload(0, OP_XFER, 0, 1, 50);
        req[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_grant", int'(grant), 0);
        rst_n = 1'b1;
`ifdef ATM_AUDIT_EN
        check("audit_ok_rst", int'(audit_ok_cnt), 0);
        check("audit_err_rst", int'(audit_err_cnt), 0);
`endif
        run(0, OP_INQ, 0, 0, 0, ST_OK, 100);
        run(1, OP_INQ, 1, 0, 0, ST_OK, 100);
        do_reset();

        // Withdraw group, then exact-balance withdrawal
        run(0, OP_WDR, 0, 0, 40, ST_OK, 60);
        run(0, OP_WDR, 0, 0, 61, ST_INS, 60);
`ifdef ATM_AUDIT_EN
        check("audit_ok_cnt", int'(audit_ok_cnt), 1);
        check("audit_err_cnt", int'(audit_err_cnt), 1);
`endif
        run(0, OP_INQ, 0, 0, 0, ST_OK, 60);
        run(1, OP_WDR, 0, 0, 60, ST_OK, 0);
        run(0, OP_INQ, 0, 0, 0, ST_OK, 0);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
